// File: rtl/dram_state_sequencer_if.sv
// Bus bundle for the DRAM state sequencer: memory command/response port plus
// the save (dump) and restore (load) beat streams.
interface dram_state_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
);
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_eof;

    modport master (
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
        input  mem_cmd_ready, mem_rsp_valid, mem_rdata,
        output dump_valid, dump_data, dump_last,
        input  dump_ready,
        input  load_valid, load_data, load_eof,
        output load_ready
    );

    modport slave (
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
        output mem_cmd_ready, mem_rsp_valid, mem_rdata,
        input  dump_valid, dump_data, dump_last,
        output dump_ready,
        output load_valid, load_data, load_eof,
        input  load_ready
    );
endinterface

// File: rtl/dram_state_sequencer.sv
// Page-by-page DRAM save/restore sequencer between host state-transfer logic and the
// memory user port. Define DRAM_STATE_SEQ_BYTESWAP_EN to apply host byte order.
module dram_state_sequencer #(
    parameter logic [31:0] START_ADDRESS  = 32'h0,
    parameter int unsigned PAGE_COUNT     = 128,
    parameter int unsigned BEATS_PER_PAGE = 128,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   save,
    input  logic                   restore,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            pages_done,
    dram_state_sequencer_if.master bus
);
    localparam int unsigned BEAT_W = (BEATS_PER_PAGE > 1) ? $clog2(BEATS_PER_PAGE) : 1;

    typedef enum logic [2:0] {
        IDLE, S_CMD, S_WAIT, S_PUSH, R_PULL, R_CMD, DONE
    } state_t;

    state_t            state_q, state_d;
    logic              save_q, restore_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       pages_q, pages_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] wdata_q, dump_data_q;
    logic [DATA_W-1:0] rsp_word, load_word;
    logic              cmd_valid_q, cmd_valid_d, we_q, we_d;
    logic              dump_valid_q, dump_valid_d, dump_last_q, dump_last_d;
    logic              load_ready_q, load_ready_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic save_edge, restore_edge, start, cmd_fire, dump_fire, load_fire;
    logic last_beat, last_page, advance;

    // Host byte order: even source bytes fill the low half, odd bytes the high half.
`ifdef DRAM_STATE_SEQ_BYTESWAP_EN
    function automatic logic [DATA_W-1:0] to_host(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8]     = w[16*i +: 8];
            r[8*i+64 +: 8]  = w[16*i+8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] from_host(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[16*i +: 8]    = w[8*i +: 8];
            r[16*i+8 +: 8]  = w[8*i+64 +: 8];
        end
        return r;
    endfunction

    assign rsp_word  = to_host(bus.mem_rdata);
    assign load_word = from_host(bus.load_data);
`else
    assign rsp_word  = bus.mem_rdata;
    assign load_word = bus.load_data;
`endif

    assign save_edge    = save & ~save_q;
    assign restore_edge = restore & ~restore_q;
    assign start        = (state_q == IDLE) && (save_edge || restore_edge);
    assign cmd_fire     = cmd_valid_q & bus.mem_cmd_ready;
    assign dump_fire    = dump_valid_q & bus.dump_ready;
    assign load_fire    = load_ready_q & bus.load_valid;
    assign last_beat    = (beat_q == BEAT_W'(BEATS_PER_PAGE - 1));
    assign last_page    = (pages_q == 32'(PAGE_COUNT - 1));
    assign advance      = dump_fire || ((state_q == R_CMD) && cmd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            save_q    <= save;
            restore_q <= restore;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (save_edge) state_d = S_CMD;
                     else if (restore_edge) state_d = R_PULL;
            S_CMD:   if (cmd_fire) state_d = S_WAIT;
            S_WAIT:  if (bus.mem_rsp_valid) state_d = S_PUSH;
            S_PUSH:  if (dump_fire) state_d = (last_beat && last_page) ? DONE : S_CMD;
            // An exhausted source may only end the operation on a page boundary.
            R_PULL:  if ((beat_q == '0) && bus.load_eof && !bus.load_valid) state_d = DONE;
                     else if (load_fire) state_d = R_CMD;
            R_CMD:   if (cmd_fire) state_d = (last_beat && last_page) ? DONE : R_PULL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and sticky error; a stray response sets error even on a start cycle.
    always_comb begin
        beat_d  = beat_q;
        pages_d = pages_q;
        addr_d  = addr_q;
        error_d = error_q;
        if (start) begin
            beat_d  = '0;
            pages_d = '0;
            addr_d  = ADDR_W'(START_ADDRESS);
            error_d = 1'b0;
        end else if (advance) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_beat) begin
                beat_d  = '0;
                pages_d = pages_q + 32'd1;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
        if (bus.mem_rsp_valid && (state_q != S_WAIT)) error_d = 1'b1;
    end

    // Outputs decoded from the next state so they are registered yet track the state.
    always_comb begin
        cmd_valid_d  = (state_d == S_CMD) || (state_d == R_CMD);
        we_d         = (state_d == R_CMD);
        dump_valid_d = (state_d == S_PUSH);
        dump_last_d  = (state_d == S_PUSH) && (beat_d == BEAT_W'(BEATS_PER_PAGE - 1));
        load_ready_d = (state_d == R_PULL);
        busy_d       = (state_d != IDLE) && (state_d != DONE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            pages_q      <= '0;
            addr_q       <= '0;
            error_q      <= 1'b0;
            wdata_q      <= '0;
            dump_data_q  <= '0;
            cmd_valid_q  <= 1'b0;
            we_q         <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            pages_q      <= pages_d;
            addr_q       <= addr_d;
            error_q      <= error_d;
            if (load_fire) wdata_q <= load_word;
            if ((state_q == S_WAIT) && bus.mem_rsp_valid) dump_data_q <= rsp_word;
            cmd_valid_q  <= cmd_valid_d;
            we_q         <= we_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign pages_done        = pages_q;
    assign bus.mem_cmd_valid = cmd_valid_q;
    assign bus.mem_cmd_we    = we_q;
    assign bus.mem_cmd_addr  = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.dump_valid    = dump_valid_q;
    assign bus.dump_data     = dump_data_q;
    assign bus.dump_last     = dump_last_q;
    assign bus.load_ready    = load_ready_q;
endmodule

// File: tb/tb_dram_state_sequencer.sv
// Directed bench for dram_state_sequencer with 2 pages x 4 beats; memory and
// load-source responders log every transfer for later comparison.
module tb_dram_state_sequencer;
    localparam logic [127:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;
`ifdef DRAM_STATE_SEQ_BYTESWAP_EN
    localparam logic [127:0] EXP_DUMP = 128'h0F0D0B0907050301_0E0C0A0806040200;
`else
    localparam logic [127:0] EXP_DUMP = PAT;
`endif

    logic        clk = 1'b0;
    logic        rst, save, restore;
    logic        busy, done, error;
    logic [31:0] pages_done;

    dram_state_sequencer_if #(.ADDR_W(32), .DATA_W(128)) bus ();

    dram_state_sequencer #(
        .START_ADDRESS(32'h0), .PAGE_COUNT(2), .BEATS_PER_PAGE(4), .ADDR_W(32), .DATA_W(128)
    ) dut (
        .clk(clk), .rst(rst), .save(save), .restore(restore),
        .busy(busy), .done(done), .error(error), .pages_done(pages_done), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic spur, rsp_hold, pat_en, load_eof_r;
    logic [127:0] load_vec [0:63];
    int load_n = 0;
    int load_idx = 0;

    logic [31:0]  rd_addr  [0:63];
    logic [31:0]  wr_addr  [0:63];
    logic [127:0] wr_data  [0:63];
    logic [127:0] dmp_data [0:63];
    logic         dmp_last [0:63];
    int rd_n = 0, wr_n = 0, dmp_n = 0, done_cnt = 0;

    assign bus.load_valid = (load_idx < load_n);
    assign bus.load_data  = load_vec[load_idx[5:0]];
    assign bus.load_eof   = load_eof_r && (load_idx >= load_n);

    // Memory model (1-cycle read latency, rdata = address), stream sinks and loggers.
    always @(posedge clk) begin
        if (rst) begin
            bus.mem_rsp_valid <= 1'b0;
        end else begin
            bus.mem_rsp_valid <= spur;
            if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                if (bus.mem_cmd_we) begin
                    if (wr_n < 64) begin
                        wr_addr[wr_n] <= bus.mem_cmd_addr;
                        wr_data[wr_n] <= bus.mem_wdata;
                    end
                    wr_n <= wr_n + 1;
                end else begin
                    if (rd_n < 64) rd_addr[rd_n] <= bus.mem_cmd_addr;
                    rd_n <= rd_n + 1;
                    if (!rsp_hold) begin
                        bus.mem_rsp_valid <= 1'b1;
                        bus.mem_rdata     <= pat_en ? PAT : {96'd0, bus.mem_cmd_addr};
                    end
                end
            end
            if (bus.dump_valid && bus.dump_ready) begin
                if (dmp_n < 64) begin
                    dmp_data[dmp_n] <= bus.dump_data;
                    dmp_last[dmp_n] <= bus.dump_last;
                end
                dmp_n <= dmp_n + 1;
            end
            if (bus.load_valid && bus.load_ready) load_idx <= load_idx + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 128'(done), 128'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctrl"}, 128'({busy, done, error, bus.mem_cmd_valid, bus.mem_cmd_we,
                                  bus.dump_valid, bus.dump_last, bus.load_ready}), 128'd0);
        chk({tag, "_pages"}, 128'(pages_done), 128'd0);
        chk({tag, "_addr"}, 128'(bus.mem_cmd_addr), 128'd0);
        chk({tag, "_data"}, 128'({bus.mem_wdata, bus.dump_data}), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, dm0, dn0, base, k;
        rst = 1'b1; save = 1'b0; restore = 1'b0;
        spur = 1'b0; rsp_hold = 1'b0; pat_en = 1'b0; load_eof_r = 1'b0;
        bus.mem_cmd_ready = 1'b1;
        bus.dump_ready    = 1'b1;
        for (int i = 0; i < 64; i++) load_vec[i] = '0;
        cyc(3);
        chk_idle_outputs("reset");
        rst = 1'b0;
        cyc(1);

        // Save of 2 pages with an initial dump stall.
        rd0 = rd_n; dm0 = dmp_n; dn0 = done_cnt;
        bus.dump_ready = 1'b0;
        save = 1'b1; cyc(1); save = 1'b0;
        k = 0;
        while (bus.dump_valid !== 1'b1 && k < 50) begin cyc(1); k++; end
        chk("t1_first_valid", 128'(bus.dump_valid), 128'd1);
        cyc(5);
        chk("t1_stall_valid", 128'(bus.dump_valid), 128'd1);
        chk("t1_stall_data", bus.dump_data, 128'd0);
        chk("t1_stall_busy", 128'(busy), 128'd1);
        bus.dump_ready = 1'b1;
        wait_done("t1_done", 200);
        chk("t1_busy_at_done", 128'(busy), 128'd0);
        chk("t1_pages", 128'(pages_done), 128'd2);
        cyc(1);
        chk("t1_done_one_cycle", 128'(done), 128'd0);
        chk("t1_read_count", 128'(rd_n - rd0), 128'd8);
        chk("t1_dump_count", 128'(dmp_n - dm0), 128'd8);
        chk("t1_done_count", 128'(done_cnt - dn0), 128'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_rd_addr%0d", i), 128'(rd_addr[rd0 + i]), 128'(i));
            chk($sformatf("t1_dump_data%0d", i), dmp_data[dm0 + i], 128'(i));
            chk($sformatf("t1_dump_last%0d", i), 128'(dmp_last[dm0 + i]), 128'((i == 3) || (i == 7)));
        end
        chk("t1_error", 128'(error), 128'd0);

        // Restore of 8 beats 0xA0..0xA7.
        base = load_idx; wr0 = wr_n; dn0 = done_cnt;
        for (int i = 0; i < 8; i++) load_vec[base + i] = 128'(32'hA0 + i);
        load_eof_r = 1'b1;
        load_n = base + 8;
        restore = 1'b1; cyc(1); restore = 1'b0;
        wait_done("t2_done", 200);
        chk("t2_pages", 128'(pages_done), 128'd2);
        chk("t2_busy_at_done", 128'(busy), 128'd0);
        cyc(1);
        chk("t2_write_count", 128'(wr_n - wr0), 128'd8);
        chk("t2_done_count", 128'(done_cnt - dn0), 128'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_wr_addr%0d", i), 128'(wr_addr[wr0 + i]), 128'(i));
            chk($sformatf("t2_wr_data%0d", i), wr_data[wr0 + i], 128'(32'hA0 + i));
        end

        // Restore ending early at the first page boundary.
        base = load_idx; wr0 = wr_n;
        for (int i = 0; i < 4; i++) load_vec[base + i] = 128'(32'hB0 + i);
        load_n = base + 4;
        restore = 1'b1; cyc(1); restore = 1'b0;
        wait_done("t3_done", 200);
        chk("t3_pages", 128'(pages_done), 128'd1);
        cyc(1);
        chk("t3_write_count", 128'(wr_n - wr0), 128'd4);
        chk("t3_last_addr", 128'(wr_addr[wr0 + 3]), 128'd3);
        chk("t3_first_data", wr_data[wr0], 128'h0B0);

        // Simultaneous edges: save wins; a restore edge while busy is dropped.
        load_eof_r = 1'b0;
        rd0 = rd_n; wr0 = wr_n;
        save = 1'b1; restore = 1'b1; cyc(1); save = 1'b0;
        cyc(2);
        chk("t4_busy", 128'(busy), 128'd1);
        chk("t4_no_load_ready", 128'(bus.load_ready), 128'd0);
        restore = 1'b0; cyc(1); restore = 1'b1; cyc(1); restore = 1'b0;
        wait_done("t4_done", 200);
        cyc(10);
        chk("t4_read_count", 128'(rd_n - rd0), 128'd8);
        chk("t4_write_count", 128'(wr_n - wr0), 128'd0);
        chk("t4_idle_after", 128'(busy), 128'd0);

        // Stray response while idle sets the sticky error.
        spur = 1'b1; cyc(1); spur = 1'b0;
        cyc(2);
        chk("err_sticky", 128'(error), 128'd1);
        cyc(3);
        chk("err_held", 128'(error), 128'd1);

        // Reset while waiting for read data aborts without done.
        rsp_hold = 1'b1; dn0 = done_cnt;
        save = 1'b1; cyc(1); save = 1'b0;
        chk("t5_err_cleared", 128'(error), 128'd0);
        chk("t5_cmd_valid", 128'(bus.mem_cmd_valid), 128'd1);
        cyc(1);
        chk("t5_in_wait", 128'({busy, bus.mem_cmd_valid, bus.dump_valid}), 128'b100);
        rst = 1'b1; cyc(1);
        chk_idle_outputs("t5_abort");
        rst = 1'b0; rsp_hold = 1'b0;
        cyc(3);
        chk("t5_no_done", 128'(done_cnt - dn0), 128'd0);
        rd0 = rd_n;
        save = 1'b1; cyc(1); save = 1'b0;
        wait_done("t5_resave_done", 200);
        chk("t5_resave_pages", 128'(pages_done), 128'd2);
        cyc(1);
        chk("t5_resave_first_addr", 128'(rd_addr[rd0]), 128'd0);
        chk("t5_resave_reads", 128'(rd_n - rd0), 128'd8);

        // Byte-order path: save a known pattern, then restore the dumped form.
        pat_en = 1'b1; dm0 = dmp_n;
        save = 1'b1; cyc(1); save = 1'b0;
        wait_done("t6_save_done", 200);
        cyc(1);
        chk("t6_dump_data", dmp_data[dm0], EXP_DUMP);
        pat_en = 1'b0;
        base = load_idx; wr0 = wr_n;
        for (int i = 0; i < 8; i++) load_vec[base + i] = EXP_DUMP;
        load_eof_r = 1'b1;
        load_n = base + 8;
        restore = 1'b1; cyc(1); restore = 1'b0;
        wait_done("t6_restore_done", 200);
        cyc(1);
        chk("t6_wr_data_first", wr_data[wr0], PAT);
        chk("t6_wr_data_last", wr_data[wr0 + 7], PAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
